// File: rtl/uart_pkg.sv
// Shared state encoding and constants for the AXI-Stream UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_MIN_CLK_PER_BIT = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering {tlast, tdata} entries ahead of the UART serialiser.
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_axis_tx.sv
// AXI-Stream to 8N1 UART transmitter with a post-tlast idle gap.
// Define UART_TX_PARITY_EN to add a parity bit and the parity_odd input.
module uart_axis_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_BITS   = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int GAP_W = (GAP_BITS < 1) ? 1 : $clog2(GAP_BITS + 1);

    tx_state_t               state;
    logic [DATA_WIDTH:0]     fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    start_now;
    logic                    ready_en;
    logic                    bit_end;
    logic [CLK_BITS-1:0]     clk_sel;
    logic [CLK_BITS-1:0]     period;
    logic [CLK_BITS-1:0]     bit_cnt;
    logic [2:0]              data_idx;
    logic [GAP_W-1:0]        gap_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    tlast_r;
`ifdef UART_TX_PARITY_EN
    logic                    tx_par;
`endif

    // ready_en holds tready low while reset is asserted, since the empty FIFO alone would not.
    assign s_axis_tready = ready_en && !fifo_full;
    assign fifo_push     = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != IDLE) || !fifo_empty;
    assign bit_end       = (bit_cnt == '0);
    assign clk_sel       = (clk_per_bit < CLK_BITS'(UART_MIN_CLK_PER_BIT))
                         ? CLK_BITS'(UART_MIN_CLK_PER_BIT) : clk_per_bit;

    // Frames chain directly out of STOP or GAP so queued bytes leave no idle cycle.
    assign start_now = !fifo_empty &&
                       ((state == IDLE) ||
                        (state == STOP && bit_end && !(tlast_r && GAP_BITS > 0)) ||
                        (state == GAP && bit_end && gap_cnt == '0));

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (start_now),
        .din   ({s_axis_tlast, s_axis_tdata}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            uart_tx    <= 1'b1;
            frame_done <= 1'b0;
            period     <= '0;
            bit_cnt    <= '0;
            data_idx   <= '0;
            gap_cnt    <= '0;
            shift_reg  <= '0;
            tlast_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else begin
            // Registered pulse lands on the final cycle of the stop bit.
            frame_done <= (state == STOP) && (bit_cnt == CLK_BITS'(1));

            if (start_now) begin
                state     <= START;
                uart_tx   <= 1'b0;
                shift_reg <= fifo_dout[DATA_WIDTH-1:0];
                tlast_r   <= fifo_dout[DATA_WIDTH];
                period    <= clk_sel;
                bit_cnt   <= clk_sel - CLK_BITS'(1);
`ifdef UART_TX_PARITY_EN
                tx_par    <= ^fifo_dout[DATA_WIDTH-1:0];
`endif
            end else begin
                case (state)
                    IDLE: begin
                        uart_tx <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            uart_tx  <= shift_reg[0];
                            data_idx <= '0;
                            bit_cnt  <= period - CLK_BITS'(1);
                        end else begin
                            bit_cnt <= bit_cnt - CLK_BITS'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_cnt <= period - CLK_BITS'(1);
                            if (data_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                uart_tx <= tx_par ^ parity_odd;
`else
                                state   <= STOP;
                                uart_tx <= 1'b1;
`endif
                            end else begin
                                data_idx  <= data_idx + 3'd1;
                                shift_reg <= shift_reg >> 1;
                                uart_tx   <= shift_reg[1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt - CLK_BITS'(1);
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                            bit_cnt <= period - CLK_BITS'(1);
                        end else begin
                            bit_cnt <= bit_cnt - CLK_BITS'(1);
                        end
                    end
                    STOP: begin
                        uart_tx <= 1'b1;
                        if (bit_end) begin
                            if (tlast_r && GAP_BITS > 0) begin
                                state   <= GAP;
                                gap_cnt <= GAP_W'(GAP_BITS - 1);
                                bit_cnt <= period - CLK_BITS'(1);
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - CLK_BITS'(1);
                        end
                    end
                    GAP: begin
                        uart_tx <= 1'b1;
                        if (bit_end) begin
                            if (gap_cnt == '0) begin
                                state <= IDLE;
                            end else begin
                                gap_cnt <= gap_cnt - GAP_W'(1);
                                bit_cnt <= period - CLK_BITS'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt - CLK_BITS'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        uart_tx <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_axis_tx.md
Name: uart_axis_tx

Overview:
AXI-Stream-to-UART transmitter. It accepts bytes on an AXI-Stream slave port, buffers them in a small FIFO and serialises them as 8N1 frames onto the TinyTapeout UART TX pin. It sits between the TCP core's outbound byte stream and the uart_tx pad. After each tlast byte it inserts an idle gap of configurable length, so the host can see packet boundaries.

Parameters:
DATA_WIDTH, 8, frame data bits; only 8 is supported.
CLK_BITS, 9, width of the runtime bit-period input.
FIFO_DEPTH, 4, input buffer entries; must be a power of two and at least 2.
GAP_BITS, 10, idle bit-times inserted after a byte tagged tlast.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH  byte to send
s_axis_tvalid  input  1  source has a byte
s_axis_tready  output  1  FIFO can accept a byte
s_axis_tlast  input  1  byte ends a packet
clk_per_bit  input  CLK_BITS  clock cycles per UART bit
uart_tx  output  1  serial line, idle high
busy  output  1  frame or gap in progress, or FIFO non-empty
frame_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: uart_tx=1, s_axis_tready=0 while reset is asserted and 1 from the first cycle after release, busy=0, frame_done=0, FIFO empty, state=IDLE.
- Handshake: a transfer occurs when tvalid&&tready on a rising edge. The {tlast,tdata} pair is written to the FIFO.
- s_axis_tready = !fifo_full, combinational from the count.
- Simultaneous push and pop leaves the count unchanged. When the FIFO is full, tready stays 0 even in a pop cycle, so there is no combinational ready-from-pop path.
- Period latch: clk_per_bit is latched when each frame starts (at the pop). A latched value below 2 is forced to 2. Changing clk_per_bit mid-frame has no effect until the next frame.
- FSM states: IDLE, START, DATA, STOP, GAP, plus PARITY when the optional feature is compiled in.
  - IDLE: if the FIFO is non-empty, pop, latch the byte, tlast and period, then go to START.
  - START: uart_tx=0 for P cycles, then DATA.
  - DATA: uart_tx=shift_reg[0], LSB first, P cycles per bit, 8 bits, counted 0..7 by a 3-bit counter. Then STOP (or PARITY).
  - STOP: uart_tx=1 for P cycles. frame_done pulses on the last cycle. Then GAP if the latched tlast is set, else IDLE.
  - GAP: uart_tx=1 for GAP_BITS*P cycles, then IDLE.
- Latency:
  - Handshake in cycle N with FIFO empty and FSM in IDLE: pop in N+1, uart_tx falls in N+2.
  - Back-to-back frames with no tlast: the next start bit immediately follows the stop bit, with zero extra idle cycles.
- Frame length: exactly 10*P cycles (11*P with parity), plus GAP_BITS*P after a tlast byte.
- Counters: the bit-period counter is CLK_BITS wide and counts down from P-1 to 0. The gap counter is sized to $clog2(GAP_GITS+1) bits and counts bit-times.
- FIFO pointers: $clog2(FIFO_DEPTH)+1 bits, wrapping naturally. Full when MSBs differ and LSBs are equal; empty when equal.
- busy = (state!=IDLE) || !fifo_empty.
- Reset mid-frame: uart_tx returns high asynchronously and the FIFO is flushed. No partial frame resumes after release.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting P cycles.
  - It drives the even parity bit (^byte) plus the runtime input parity_odd, a new 1-bit input port; when parity_odd=1 the bit is inverted.
  - Frames are 11 bit-times.
- Undefined: no PARITY state, no parity_odd port, 8N1 only.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP, GAP}. PARITY is always enumerated so encodings stay stable.
  - Constants: UART_DATA_BITS=8, UART_MIN_CLK_PER_BIT=2.
- Sub-module uart_tx_fifo: synchronous FIFO parameterised by width (DATA_WIDTH+1) and depth. It exposes push, pop, dout, full, empty.
- The FSM and bit-timing counter live in uart_axis_tx.

Test Plan:
- Single byte, clk_per_bit=4: push 0x55 with tlast=0.
  - Expect uart_tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles.
  - frame_done pulses once, 40 cycles after the start-bit falling edge.
- Burst fill, clk_per_bit=8: hold tvalid for 6 bytes 0x01..0x06 while the line is busy.
  - tready drops after the 5th accept (4 in FIFO + 1 in shifter).
  - All 6 bytes are transmitted in order with no idle between frames.
- Packet gap, clk_per_bit=4: bytes 0xA0 (tlast=1) then 0xA1.
  - After the 0xA0 stop bit, uart_tx stays 1 for exactly 40 cycles before the 0xA1 start bit.
- Minimum period: clk_per_bit=0 and then 1, byte 0xFF.
  - Each bit lasts 2 cycles; frame is 20 cycles.
- Reset mid-frame: deassert rst_n during data bit 3 of 0x3C with 2 bytes queued.
  - uart_tx=1 immediately and busy=0.
  - After release, no frames are emitted until new input arrives.
- Parity build (UART_TX_PARITY_EN), clk_per_bit=4, byte 0x07, parity_odd=0: the parity bit is 1 and the frame is 44 cycles. With parity_odd=1 the parity bit is 0.
